// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Byte-serial loaded instruction memory for a single-cycle core;
//                holds the core in reset until the program is loaded.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem_loader #(
    parameter int          ADDR_SIZE = 6,
    parameter logic [31:0] HALT_WORD = 32'h0000000D
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [7:0]           load_byte,
    input  logic                 load_last,
    input  logic [31:0]          raddr,
    output logic [31:0]          instr,
    output logic                 core_reset,
    input  logic                 halted,
    output logic                 done,
    output logic                 load_err,
    output logic [ADDR_SIZE:0]   words_loaded
);

    localparam int c_DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_byte_idx;
    logic [ADDR_SIZE-1:0]   r_wptr;
    logic [31:0]            r_acc;
    logic [c_DEPTH-1:0]     r_valid;
    logic [31:0]            r_mem [c_DEPTH];
    logic                   r_core_reset;
    logic                   r_load_err;
    logic [ADDR_SIZE:0]     r_words;

    logic                   w_xfer;
    logic                   w_commit;
    logic [31:0]            w_word;
    logic                   w_in_range;
    logic [ADDR_SIZE-1:0]   w_ridx;

    assign w_xfer   = load_valid && (r_state == S_LOAD);
    assign w_commit = w_xfer && (load_last || (r_byte_idx == 2'd3));

    // Big-endian placement: byte k of a word lands in bits [31-8k -: 8]
    assign w_word   = r_acc | ({load_byte, 24'h000000} >> {r_byte_idx, 3'b000});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_byte_idx   <= 2'd0;
            r_wptr       <= '0;
            r_acc        <= 32'h0;
            r_valid      <= '0;
            r_core_reset <= 1'b1;
            r_load_err   <= 1'b0;
            r_words      <= '0;
        end else begin
            // Lags state by one cycle so the core still sees reset as RUN begins
            r_core_reset <= (r_state == S_LOAD);
            case (r_state)
                S_LOAD: begin
                    if (w_xfer) begin
                        if (w_commit) begin
                            r_valid[r_wptr] <= 1'b1;
                            r_wptr          <= r_wptr + 1'b1;
                            r_words         <= r_words + 1'b1;
                            r_byte_idx      <= 2'd0;
                            r_acc           <= 32'h0;
                            if (load_last) begin
                                r_state <= S_RUN;
                            end else if (&r_wptr) begin
                                r_state    <= S_RUN;
                                r_load_err <= 1'b1;
                            end
                        end else begin
                            r_acc      <= w_word;
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (halted) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Storage carries no reset; the valid bitmap decides what is visible
    always_ff @(posedge clock) begin
        if (!reset && w_commit) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    assign w_in_range = (raddr[31:ADDR_SIZE] == '0);
    assign w_ridx     = raddr[ADDR_SIZE-1:0];

    always_comb begin
        instr = HALT_WORD;
        if ((r_state == S_RUN) && w_in_range && r_valid[w_ridx]) begin
            instr = r_mem[w_ridx];
        end
    end

    assign load_ready   = (r_state == S_LOAD);
    assign done         = (r_state == S_DONE);
    assign core_reset   = r_core_reset;
    assign load_err     = r_load_err;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Self-checking bench for instr_mem_loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int          AW   = 6;
    localparam logic [31:0] HALT = 32'h0000000D;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_last = 1'b0;
    logic          halted = 1'b0;
    logic [7:0]    load_byte = 8'h00;
    logic [31:0]   raddr = 32'h0;
    logic          load_ready;
    logic          core_reset;
    logic          done;
    logic          load_err;
    logic [31:0]   instr;
    logic [AW:0]   words_loaded;

    int errors = 0;
    int checks = 0;

    instr_mem_loader #(.ADDR_SIZE(AW), .HALT_WORD(HALT)) dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_byte    (load_byte),
        .load_last    (load_last),
        .raddr        (raddr),
        .instr        (instr),
        .core_reset   (core_reset),
        .halted       (halted),
        .done         (done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        halted     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int k);
        load_valid = 1'b0;
        repeat (k) @(posedge clock);
        #1;
    endtask

    // One cycle per call; acc reports whether the loader took the byte
    task automatic send_byte(input logic [7:0] b, input logic l, output bit acc);
        @(negedge clock);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = l;
        acc        = load_ready;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        check(name, instr, exp);
    endtask

    // Reference: byte j belongs to word j/4 at shift 24-8*(j%4); words beyond 64 are dropped
    task automatic run_random(input int n, input bit use_last);
        logic [31:0] m [64];
        bit          v [64];
        logic [7:0]  b;
        bit          acc;
        int          wexp;
        for (int i = 0; i < 64; i++) begin
            m[i] = 32'h0;
            v[i] = 1'b0;
        end
        do_reset();
        for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            b = 8'($urandom);
            send_byte(b, use_last && (j == n - 1), acc);
            if (j >= 255) check($sformatf("rnd_accept_b%0d", j), 32'(acc), 32'(j < 256));
            if (j < 256) begin
                m[j / 4] = m[j / 4] | (32'(b) << (24 - 8 * (j % 4)));
                v[j / 4] = 1'b1;
            end
        end
        wexp = use_last ? (n + 3) / 4 : 64;
        check("rnd_words", 32'(words_loaded), 32'(wexp));
        check("rnd_err", 32'(load_err), 32'(!use_last));
        check("rnd_ready", 32'(load_ready), 32'h0);
        idle(1);
        check("rnd_core_reset", 32'(core_reset), 32'h0);
        for (int a = 0; a < 64; a++) begin
            read_chk($sformatf("rnd_instr_a%0d", a), 32'(a), v[a] ? m[a] : HALT);
        end
        read_chk("rnd_high_addr", 32'($urandom) | (32'h1 << $urandom_range(AW, 31)), HALT);
    endtask

    initial begin
        vec_t        tbl [7];
        logic [7:0]  p1 [8];
        logic [7:0]  p2 [5];
        bit          acc;

        p1 = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0D};
        p2 = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'hAB};
        tbl[0] = '{32'h0000_0000, 32'h2002_0005};
        tbl[1] = '{32'h0000_0001, 32'h0000_000D};
        tbl[2] = '{32'h0000_0002, HALT};
        tbl[3] = '{32'h0000_003F, HALT};
        tbl[4] = '{32'h0000_0040, HALT};
        tbl[5] = '{32'h0000_0100, HALT};
        tbl[6] = '{32'h8000_0000, HALT};

        // Reset state
        do_reset();
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_core_reset", 32'(core_reset), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(load_err), 32'h0);
        check("rst_words", 32'(words_loaded), 32'h0);
        read_chk("rst_instr", 32'h0, HALT);

        // Two-word program, last on byte 8
        for (int i = 0; i < 8; i++) send_byte(p1[i], i == 7, acc);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_ready", 32'(load_ready), 32'h0);
        check("t1_core_reset_hold", 32'(core_reset), 32'h1);
        idle(1);
        check("t1_core_reset_rel", 32'(core_reset), 32'h0);
        for (int i = 0; i < 7; i++) begin
            read_chk($sformatf("t1_vec%0d", i), tbl[i].raddr, tbl[i].exp);
        end

        // Partial last word is zero padded
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(p2[i], i == 4, acc);
        check("t2_words", 32'(words_loaded), 32'd2);
        check("t2_core_reset_hold", 32'(core_reset), 32'h1);
        idle(1);
        check("t2_core_reset_rel", 32'(core_reset), 32'h0);
        read_chk("t2_w0", 32'h0, 32'h3C01_1234);
        read_chk("t2_w1", 32'h1, 32'hAB00_0000);

        // Reset mid-load discards partial state
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(8'hF0 + i), 1'b0, acc);
        do_reset();
        check("t5_words", 32'(words_loaded), 32'h0);
        check("t5_ready", 32'(load_ready), 32'h1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0, acc);
        check("t5_words1", 32'(words_loaded), 32'h1);
        check("t5_ready1", 32'(load_ready), 32'h1);
        read_chk("t5_instr_load", 32'h0, HALT);
        send_byte(8'h11, 1'b1, acc);
        idle(1);
        read_chk("t5_w0", 32'h0, 32'h0000_0000);
        read_chk("t5_w1", 32'h1, 32'h1100_0000);
        read_chk("t5_w2", 32'h2, HALT);

        // Idle gap mid-word
        do_reset();
        send_byte(8'hAA, 1'b0, acc);
        send_byte(8'hBB, 1'b0, acc);
        idle(10);
        send_byte(8'hCC, 1'b0, acc);
        send_byte(8'hDD, 1'b1, acc);
        idle(1);
        check("t6_words", 32'(words_loaded), 32'h1);
        read_chk("t6_w0", 32'h0, 32'hAABB_CCDD);
        read_chk("t6_oor", 32'h0000_0100, HALT);

        // Halt: done sticky, instr forced, loads ignored
        @(negedge clock);
        halted = 1'b1;
        @(posedge clock);
        #1;
        halted = 1'b0;
        check("t4_done", 32'(done), 32'h1);
        read_chk("t4_instr0", 32'h0, HALT);
        send_byte(8'h55, 1'b1, acc);
        check("t4_accept", 32'(acc), 32'h0);
        check("t4_words", 32'(words_loaded), 32'h1);
        idle(3);
        check("t4_done_sticky", 32'(done), 32'h1);
        read_chk("t4_instr1", 32'h0, HALT);

        // Randomized programs against the reference model
        run_random(257, 1'b0);
        run_random(256, 1'b1);
        for (int k = 0; k < 3; k++) run_random($urandom_range(1, 255), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
